// File: rtl/score_keeper_if.sv
// Interface bundling the score_keeper game inputs and status outputs.
// master: frame_i, dodge_i, hit_i, start_i out; status in. slave: the reverse.
interface score_keeper_if #(
    parameter int SPR_CNT = 5,
    parameter int SCOREW  = 8,
    parameter int LEVELW  = 3
);
    logic               frame_i;
    logic [SPR_CNT-1:0] dodge_i;
    logic               hit_i;
    logic               start_i;
    logic [1:0]         state_o;
    logic [SCOREW-1:0]  score_o;
    logic [SCOREW-1:0]  high_score_o;
    logic [LEVELW-1:0]  level_o;
    logic               freeze_o;
    logic               flash_o;

    modport master (
        output frame_i, dodge_i, hit_i, start_i,
        input  state_o, score_o, high_score_o,
        input  level_o, freeze_o, flash_o
    );

    modport slave (
        input  frame_i, dodge_i, hit_i, start_i,
        output state_o, score_o, high_score_o,
        output level_o, freeze_o, flash_o
    );
endinterface

// File: rtl/score_keeper.sv
// SuperFrog game-state FSM with saturating score, high score and level.
// Ports: clk_pix, rst_n (async active-low), bus (score_keeper_if.slave).
module score_keeper #(
    parameter int SPR_CNT      = 5,
    parameter int SCOREW       = 8,
    parameter int SCORE_MAX    = 255,
    parameter int LEVEL_STEP   = 16,
    parameter int LEVELW       = 3,
    parameter int DEATH_FRAMES = 120
) (
    input  logic          clk_pix,
    input  logic          rst_n,
    score_keeper_if.slave bus
);

    typedef enum logic [1:0] {
        ATTRACT = 2'd0,
        PLAY    = 2'd1,
        DYING   = 2'd2,
        OVER    = 2'd3
    } state_e;

    localparam int SW      = SCOREW + 3;
    localparam int FCW_MIN = $clog2(DEATH_FRAMES + 1);
    // flash taps bit 3, so keep at least 4 bits
    localparam int FCW     = (FCW_MIN > 4) ? FCW_MIN : 4;

    localparam logic [SW-1:0]     SMAX_W = SW'(SCORE_MAX);
    localparam logic [SCOREW-1:0] SMAX   = SCOREW'(SCORE_MAX);
    localparam logic [SCOREW-1:0] STEP   = SCOREW'(LEVEL_STEP);
    localparam logic [SCOREW-1:0] LMAX_W = SCOREW'((1 << LEVELW) - 1);
    localparam logic [FCW-1:0]    LAST_F = FCW'(DEATH_FRAMES - 1);

    state_e              state_q, state_d;
    logic [SCOREW-1:0]   score_q, score_d;
    logic [SCOREW-1:0]   hs_q, hs_d;
    logic [LEVELW-1:0]   level_q, level_d;
    logic [FCW-1:0]      fcnt_q, fcnt_d;
    logic                start_q;
    logic                freeze_q;

    logic                start_rise;
    logic [SW-1:0]       pop;
    logic [SW-1:0]       sum_w;
    logic [SCOREW-1:0]   lvl_raw;

    assign start_rise = bus.start_i & ~start_q;

    always_comb begin
        pop = '0;
        for (int m = 0; m < SPR_CNT; m++) begin
            pop = pop + SW'(bus.dodge_i[m]);
        end
    end

    // Wide sum cannot wrap, so the saturation compare is exact
    assign sum_w = SW'(score_q) + pop;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        hs_d    = hs_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            ATTRACT, OVER: begin
                if (start_rise) begin
                    state_d = PLAY;
                    score_d = '0;
                end
            end
            PLAY: begin
                score_d = (sum_w > SMAX_W) ? SMAX : sum_w[SCOREW-1:0];
                if (bus.hit_i) begin
                    state_d = DYING;
                    fcnt_d  = '0;
                end
            end
            DYING: begin
                if (bus.frame_i) begin
                    if (fcnt_q == LAST_F) begin
                        state_d = OVER;
                        fcnt_d  = '0;
                        hs_d    = (score_q > hs_q) ? score_q : hs_q;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ATTRACT;
        endcase
    end

    always_comb begin
        lvl_raw = score_d / STEP;
        level_d = (lvl_raw > LMAX_W) ? LMAX_W[LEVELW-1:0]
                                     : lvl_raw[LEVELW-1:0];
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ATTRACT;
            score_q  <= '0;
            hs_q     <= '0;
            level_q  <= '0;
            fcnt_q   <= '0;
            // A button held through reset must not look like a press
            start_q  <= 1'b1;
            freeze_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            hs_q     <= hs_d;
            level_q  <= level_d;
            fcnt_q   <= fcnt_d;
            start_q  <= bus.start_i;
            freeze_q <= (state_d != PLAY);
        end
    end

    assign bus.state_o      = state_q;
    assign bus.score_o      = score_q;
    assign bus.high_score_o = hs_q;
    assign bus.level_o      = level_q;
    assign bus.freeze_o     = freeze_q;
    assign bus.flash_o      = (state_q == DYING) & fcnt_q[3];

endmodule
